// File: rtl/psum_deskew_collector.sv
// ============================================================================
// psum_deskew_collector
// ----------------------------------------------------------------------------
// Collects partial-sum results leaving the bottom row of the systolic PE
// array. Each column delivers its result one cycle after the column to its
// left. This block realigns the COLS columns into one row and buffers the
// rows in a FIFO, which drains toward the output SRAM writer through a
// valid/ready handshake.
//
// Ports
//   CLK        in   clock; all state updates on the rising edge
//   ASYNC_RST  in   asynchronous reset, active-low
//   SYNC_RST   in   synchronous reset, active-high; same clear as ASYNC_RST
//   EN         in   array advance enable; 0 freezes the de-skew stage only
//   PsumValid  in   column-0 result of a new row is on PsumIn this cycle
//   PsumIn     in   COLS signed elements, column c at [c*W +: W]
//   OutReady   in   downstream accepts OutRow this cycle
//   OutValid   out  OutRow holds the FIFO head row
//   OutRow     out  aligned row, same packing as PsumIn; 0 when empty
//   AlmostFull out  Count >= DEPTH-COLS; controller stops issuing rows
//   Count      out  rows currently stored
//   Overflow   out  sticky: a row was dropped because the FIFO was full
// ============================================================================
module psum_deskew_collector #(
  parameter int COLS                   = 4,
  parameter int ACCUMULATOR_DATA_WIDTH = 32,
  parameter int DEPTH                  = 8
) (
  input  logic                                   CLK,
  input  logic                                   ASYNC_RST,
  input  logic                                   SYNC_RST,
  input  logic                                   EN,
  input  logic                                   PsumValid,
  input  logic [COLS*ACCUMULATOR_DATA_WIDTH-1:0] PsumIn,
  input  logic                                   OutReady,
  output logic                                   OutValid,
  output logic [COLS*ACCUMULATOR_DATA_WIDTH-1:0] OutRow,
  output logic                                   AlmostFull,
  output logic [$clog2(DEPTH):0]                 Count,
  output logic                                   Overflow
);

  localparam int W  = ACCUMULATOR_DATA_WIDTH;
  localparam int RW = COLS * W;
  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW + 1)'(DEPTH - COLS);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);
  localparam logic [AW:0] ZERO_C  = (AW + 1)'(0);

  // --------------------------------------------------------------------------
  // De-skew stage
  // --------------------------------------------------------------------------
  // vpipe_r[COLS-2] marks the EN edge on which the last column of a row is
  // present on PsumIn, i.e. the row is complete and gets pushed.
  logic [COLS-2:0] vpipe_r;
  logic [RW-1:0]   row_s;

  // Valid pipe: carries PsumValid alongside the slowest column.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      vpipe_r <= {(COLS - 1){1'b0}};
    end else if (SYNC_RST) begin
      vpipe_r <= {(COLS - 1){1'b0}};
    end else if (EN) begin
      vpipe_r[0] <= PsumValid;
      for (int i = 1; i < COLS - 1; i++) begin
        vpipe_r[i] <= vpipe_r[i - 1];
      end
    end
  end

  // Column c arrives c edges after column 0, so it is delayed by COLS-1-c
  // registers to line up with the last column, which is used directly.
  for (genvar c = 0; c < COLS - 1; c++) begin : g_col
    localparam int NS = COLS - 1 - c;
    logic [W-1:0] stage_r [NS];

    // Per-column delay line, frozen while EN is low.
    always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
        for (int k = 0; k < NS; k++) begin
          stage_r[k] <= {W{1'b0}};
        end
      end else if (SYNC_RST) begin
        for (int k = 0; k < NS; k++) begin
          stage_r[k] <= {W{1'b0}};
        end
      end else if (EN) begin
        stage_r[0] <= PsumIn[c*W +: W];
        for (int k = 1; k < NS; k++) begin
          stage_r[k] <= stage_r[k - 1];
        end
      end
    end

    assign row_s[c*W +: W] = stage_r[NS - 1];
  end : g_col

  assign row_s[(COLS-1)*W +: W] = PsumIn[(COLS-1)*W +: W];

  // --------------------------------------------------------------------------
  // Row FIFO
  // --------------------------------------------------------------------------
  logic [RW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          out_valid_r;
  logic          almost_full_r;
  logic          overflow_r;

  logic          push_req_s;
  logic          pop_s;
  logic          full_s;
  logic          wr_en_s;
  logic          drop_s;
  logic [AW:0]   count_nxt_s;

  // Handshake decode. A push into a full FIFO is only accepted when a pop
  // frees the head slot on the same edge; otherwise the row is dropped.
  always_comb begin
    push_req_s  = EN & vpipe_r[COLS-2] & ~SYNC_RST;
    pop_s       = (count_r != ZERO_C) & OutReady & ~SYNC_RST;
    full_s      = (count_r == DEPTH_C);
    wr_en_s     = push_req_s & (~full_s | pop_s);
    drop_s      = push_req_s & full_s & ~pop_s;
    count_nxt_s = count_r;
    if (wr_en_s && !pop_s) begin
      count_nxt_s = count_r + ONE_C;
    end else if (pop_s && !wr_en_s) begin
      count_nxt_s = count_r - ONE_C;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Row storage; no reset needed because OutRow is masked while empty.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= row_s;
    end
  end

  // Pointers, occupancy, and status flags registered from next-state count.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= ZERO_C;
      out_valid_r   <= 1'b0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else if (SYNC_RST) begin
      wr_ptr_r      <= {AW{1'b0}};
      rd_ptr_r      <= {AW{1'b0}};
      count_r       <= ZERO_C;
      out_valid_r   <= 1'b0;
      almost_full_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r       <= count_nxt_s;
      out_valid_r   <= (count_nxt_s != ZERO_C);
      almost_full_r <= (count_nxt_s >= AF_C);
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Head row presented combinationally; forced to zero when nothing is stored.
  always_comb begin
    if (out_valid_r) begin
      OutRow = mem_r[rd_ptr_r];
    end else begin
      OutRow = {RW{1'b0}};
    end
  end

  assign OutValid   = out_valid_r;
  assign AlmostFull = almost_full_r;
  assign Count      = count_r;
  assign Overflow   = overflow_r;

endmodule
